// File: rtl/dice_game_pkg.sv
// Shared types for the dice board game: FSM state encoding, die color codes
// and the color-to-steps mapping used when a roll is accepted.
package dice_game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_WAIT_COLOR  = 3'd1,
    ST_MOVE        = 3'd2,
    ST_WAIT_CLEAR  = 3'd3,
    ST_NEXT_PLAYER = 3'd4,
    ST_GAME_OVER   = 3'd5
  } game_state_e;

  typedef enum logic [1:0] {
    COLOR_NONE  = 2'b00,
    COLOR_RED   = 2'b01,
    COLOR_GREEN = 2'b10,
    COLOR_BLUE  = 2'b11
  } color_e;

  function automatic logic [1:0] color_to_steps(input color_e color);
    logic [1:0] steps;
    case (color)
      COLOR_RED:   steps = 2'd1;
      COLOR_GREEN: steps = 2'd2;
      COLOR_BLUE:  steps = 2'd3;
      default:     steps = 2'd0;
    endcase
    return steps;
  endfunction

endpackage

// File: rtl/step_timer.sv
// Free-running down-counter that paces piece movement: tick fires once every
// STEP_CYCLES enabled cycles, counting from the most recent load.
module step_timer #(
  parameter int STEP_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic tick
);

  localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(STEP_CYCLES - 1);

  logic [CW-1:0] count;

  assign tick = en && (count == '0);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load || tick) begin
      count <= RELOAD;
    end else if (en) begin
      count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/dice_turn_controller.sv
// Turn sequencer for a color-die board game: accepts a qualified die color,
// walks the current player's piece one square per step period, and rotates turns.
module dice_turn_controller
  import dice_game_pkg::*;
#(
  parameter int          NUM_PLAYERS    = 2,
  parameter int          TRACK_LEN      = 20,
  parameter int          STEP_CYCLES    = 4,
  parameter logic [15:0] MIN_CONFIDENCE = 16'd100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  detected_color,
  input  logic        color_result_ready,
  input  logic        turn_end,
  input  logic [15:0] color_confidence,
  output logic [1:0]  cur_player,
  output logic [19:0] player_pos,
  output logic [2:0]  game_state,
  output logic        step_pulse,
  output logic        game_over,
  output logic [1:0]  winner
);

  localparam logic [4:0] FINISH      = 5'(TRACK_LEN - 1);
  localparam logic [1:0] LAST_PLAYER = 2'(NUM_PLAYERS - 1);

  game_state_e     state_q, state_d;
  logic [1:0]      cur_q;
  logic [3:0][4:0] pos_q;
  logic [1:0]      steps_q;
  logic [1:0]      winner_q;
  logic            step_pulse_q;
  logic            game_over_q;

  logic       tick;
  logic       roll_ok;
  logic       clear_game;
  logic       accept_roll;
  logic       do_step;
  logic       advance;
  logic [4:0] pos_cur;
  logic [4:0] pos_inc;
  logic       hits_finish;

  step_timer #(
    .STEP_CYCLES(STEP_CYCLES)
  ) u_step_timer (
    .clk  (clk),
    .reset(reset),
    .load (accept_roll),
    .en   (state_q == ST_MOVE),
    .tick (tick)
  );

  assign roll_ok = color_result_ready
                && (color_e'(detected_color) != COLOR_NONE)
                && (color_confidence >= MIN_CONFIDENCE);

  // Saturating advance keeps the piece from ever passing the finish square.
  assign pos_cur     = pos_q[cur_q];
  assign pos_inc     = (pos_cur >= FINISH) ? FINISH : pos_cur + 5'd1;
  assign hits_finish = (pos_inc == FINISH);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    clear_game  = 1'b0;
    accept_roll = 1'b0;
    do_step     = 1'b0;
    advance     = 1'b0;
    case (state_q)
      ST_IDLE, ST_GAME_OVER: begin
        if (start) begin
          clear_game = 1'b1;
          state_d    = ST_WAIT_COLOR;
        end
      end
      ST_WAIT_COLOR: begin
        // turn_end is meaningless here, even when it coincides with a roll.
        if (roll_ok) begin
          accept_roll = 1'b1;
          state_d     = ST_MOVE;
        end
      end
      ST_MOVE: begin
        if (tick) begin
          do_step = 1'b1;
          if (hits_finish)           state_d = ST_GAME_OVER;
          else if (steps_q == 2'd1)  state_d = ST_WAIT_CLEAR;
        end
      end
      ST_WAIT_CLEAR: begin
        if (turn_end) state_d = ST_NEXT_PLAYER;
      end
      ST_NEXT_PLAYER: begin
        advance = 1'b1;
        state_d = ST_WAIT_COLOR;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: the position array is a handful of flops, not a RAM, so it is reset
  // along with the rest of the game state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_q        <= '0;
      pos_q        <= '0;
      steps_q      <= '0;
      winner_q     <= '0;
      step_pulse_q <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      step_pulse_q <= do_step;
      game_over_q  <= (state_d == ST_GAME_OVER);
      if (clear_game) begin
        cur_q    <= '0;
        pos_q    <= '0;
        steps_q  <= '0;
        winner_q <= '0;
      end
      if (accept_roll) steps_q <= color_to_steps(color_e'(detected_color));
      if (do_step) begin
        pos_q[cur_q] <= pos_inc;
        steps_q      <= steps_q - 2'd1;
        if (hits_finish) winner_q <= cur_q;
      end
      if (advance) cur_q <= (cur_q == LAST_PLAYER) ? 2'd0 : cur_q + 2'd1;
    end
  end

  assign cur_player = cur_q;
  assign player_pos = pos_q;
  assign game_state = state_q;
  assign step_pulse = step_pulse_q;
  assign game_over  = game_over_q;
  assign winner     = winner_q;

endmodule

// File: tb/tb_dice_turn_controller.sv
// Self-checking bench for dice_turn_controller: directed game scenarios followed
// by randomized turns, all compared against a board-level model of the game.
module tb_dice_turn_controller;
  import dice_game_pkg::*;

  localparam int NP  = 2;
  localparam int TL  = 20;
  localparam int SC  = 4;
  localparam int FIN = TL - 1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  detected_color = 2'b00;
  logic        color_result_ready = 1'b0;
  logic        turn_end = 1'b0;
  logic [15:0] color_confidence = 16'd0;
  logic [1:0]  cur_player;
  logic [19:0] player_pos;
  logic [2:0]  game_state;
  logic        step_pulse;
  logic        game_over;
  logic [1:0]  winner;

  dice_turn_controller #(
    .NUM_PLAYERS(NP), .TRACK_LEN(TL), .STEP_CYCLES(SC), .MIN_CONFIDENCE(16'd100)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .detected_color(detected_color),
    .color_result_ready(color_result_ready), .turn_end(turn_end),
    .color_confidence(color_confidence), .cur_player(cur_player),
    .player_pos(player_pos), .game_state(game_state), .step_pulse(step_pulse),
    .game_over(game_over), .winner(winner)
  );

  always #20 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Board model: square of each player, whose turn it is, and game result.
  int m_pos[4];
  int m_cur;
  int m_win;
  bit m_over;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic [19:0] model_vec();
    logic [19:0] v;
    v = '0;
    for (int i = 0; i < 4; i++) v[5*i +: 5] = 5'(m_pos[i]);
    return v;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 4; i++) m_pos[i] = 0;
    m_cur  = 0;
    m_win  = 0;
    m_over = 1'b0;
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, "_pos"}, player_pos, model_vec());
    check({tag, "_cur"}, cur_player, m_cur);
    check({tag, "_over"}, game_over, m_over);
    if (m_over) check({tag, "_winner"}, winner, m_win);
  endtask

  task automatic pulse_inputs(input bit s, input bit rdy, input logic [1:0] col,
                              input int conf, input bit te);
    @(negedge clk);
    start = s; color_result_ready = rdy; detected_color = col;
    color_confidence = 16'(conf); turn_end = te;
    @(negedge clk);
    start = 1'b0; color_result_ready = 1'b0; detected_color = 2'b00;
    color_confidence = 16'd0; turn_end = 1'b0;
  endtask

  task automatic do_start();
    pulse_inputs(1'b1, 1'b0, 2'b00, 0, 1'b0);
    model_clear();
    check("start_state", game_state, ST_WAIT_COLOR);
    check_outputs("start");
  endtask

  task automatic watch_move(input int steps);
    int exp_n;
    int seen;
    int cyc;
    bit done;
    exp_n = (steps < FIN - m_pos[m_cur]) ? steps : FIN - m_pos[m_cur];
    seen = 0; cyc = 0; done = 1'b0;
    while (!done && cyc < SC * 3 + 4) begin
      @(negedge clk);
      cyc++;
      if (step_pulse) begin
        seen++;
        check("step_time", cyc, SC * seen);
      end
      if (game_state != ST_MOVE) done = 1'b1;
    end
    if (!done) check("move_timeout", 0, 1);
    check("step_count", seen, exp_n);
    m_pos[m_cur] += exp_n;
    if (m_pos[m_cur] == FIN) begin
      m_over = 1'b1;
      m_win  = m_cur;
    end
    check("post_move_state", game_state, m_over ? ST_GAME_OVER : ST_WAIT_CLEAR);
    check_outputs("move");
  endtask

  task automatic do_roll(input logic [1:0] col, input int conf, input bit te, output bit acc);
    acc = (col != 2'b00) && (conf >= 100);
    pulse_inputs(1'b0, 1'b1, col, conf, te);
    if (acc) begin
      check("roll_accept_state", game_state, ST_MOVE);
      watch_move(int'(col));
    end else begin
      check("roll_reject_state", game_state, ST_WAIT_COLOR);
      check_outputs("reject");
    end
  endtask

  task automatic end_turn();
    pulse_inputs(1'b0, 1'b0, 2'b00, 0, 1'b1);
    check("next_player_state", game_state, ST_NEXT_PLAYER);
    @(negedge clk);
    m_cur = (m_cur + 1) % NP;
    check("after_turn_state", game_state, ST_WAIT_COLOR);
    check_outputs("turn");
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int seen;
    int pulses;
    logic [1:0] p1_cols[6];

    model_clear();
    repeat (3) @(negedge clk);
    check("reset_state", game_state, ST_IDLE);
    check("reset_pulse", step_pulse, 1'b0);
    check_outputs("reset");
    reset = 1'b1;

    // Color results are meaningless before a game starts.
    pulse_inputs(1'b0, 1'b1, COLOR_BLUE, 500, 1'b0);
    check("idle_ignore_roll", game_state, ST_IDLE);

    do_start();
    do_roll(COLOR_RED, 150, 1'b0, acc);

    pulse_inputs(1'b0, 1'b1, COLOR_BLUE, 500, 1'b0);
    pulse_inputs(1'b0, 1'b1, COLOR_BLUE, 500, 1'b0);
    check("clear_ignore_roll", game_state, ST_WAIT_CLEAR);
    pulse_inputs(1'b1, 1'b0, 2'b00, 0, 1'b0);
    check("clear_ignore_start", game_state, ST_WAIT_CLEAR);
    check_outputs("clear_ignore");
    end_turn();

    do_roll(COLOR_BLUE, 99, 1'b0, acc);
    do_roll(COLOR_NONE, 500, 1'b0, acc);
    pulse_inputs(1'b0, 1'b0, 2'b00, 0, 1'b1);
    check("wait_ignore_turn_end", game_state, ST_WAIT_COLOR);
    do_roll(COLOR_GREEN, 100, 1'b0, acc);
    end_turn();

    do_roll(COLOR_RED, 200, 1'b1, acc);
    end_turn();

    pulse_inputs(1'b1, 1'b0, 2'b00, 0, 1'b0);
    check("wait_ignore_start", game_state, ST_WAIT_COLOR);
    check_outputs("wait_ignore_start");

    // Walk player 1 to square 18 while player 0 creeps forward with REDs.
    p1_cols = '{COLOR_BLUE, COLOR_BLUE, COLOR_BLUE, COLOR_BLUE, COLOR_BLUE, COLOR_RED};
    for (int i = 0; i < 6; i++) begin
      do_roll(p1_cols[i], 300, 1'b0, acc);
      end_turn();
      do_roll(COLOR_RED, 300, 1'b0, acc);
      end_turn();
    end
    check("pre_win_pos1", player_pos[9:5], 5'd18);
    do_roll(COLOR_BLUE, 300, 1'b0, acc);
    check("win_winner", winner, 2'd1);
    pulse_inputs(1'b0, 1'b1, COLOR_BLUE, 500, 1'b0);
    check("over_hold_state", game_state, ST_GAME_OVER);
    check_outputs("over_hold");
    do_start();

    // Reset in the middle of a BLUE move discards the remaining steps.
    pulse_inputs(1'b0, 1'b1, COLOR_BLUE, 400, 1'b0);
    seen = 0;
    for (int i = 0; i < SC + 3 && seen == 0; i++) begin
      @(negedge clk);
      if (step_pulse) seen = 1;
    end
    check("reset_first_step_seen", seen, 1);
    #5 reset = 1'b0;
    #1;
    model_clear();
    check("async_reset_state", game_state, ST_IDLE);
    check("async_reset_pulse", step_pulse, 1'b0);
    check_outputs("async_reset");
    @(negedge clk);
    reset = 1'b1;
    pulses = 0;
    for (int i = 0; i < 3 * SC; i++) begin
      @(negedge clk);
      if (step_pulse) pulses++;
    end
    check("post_reset_no_steps", pulses, 0);
    check("post_reset_idle", game_state, ST_IDLE);
    check_outputs("post_reset");

    // Randomized play against the board model.
    do_start();
    for (int t = 0; t < 200; t++) begin
      logic [1:0] col;
      int conf;
      bit te;
      col = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       conf = $urandom_range(0, 99);
        1:       conf = 100;
        2:       conf = 99;
        default: conf = $urandom_range(100, 65535);
      endcase
      te = 1'($urandom_range(0, 1));
      do_roll(col, conf, te, acc);
      if (!acc) continue;
      if (m_over) begin
        do_start();
      end else begin
        if ($urandom_range(0, 3) == 0) begin
          pulse_inputs(1'($urandom_range(0, 1)), 1'b1, 2'($urandom_range(1, 3)), 1000, 1'b0);
          check("rand_clear_hold", game_state, ST_WAIT_CLEAR);
          check_outputs("rand_clear_hold");
        end
        end_turn();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
